counter_step_arbiter: RTL

//  Shares one modulo-m up/down counter between N requesters.

---
 rtl/counter_step_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/counter_step_arbiter.sv
// Round-robin arbiter sharing one modulo-M up/down counter among N requesters.
// The winner's burst of LEN steps is applied one step per cycle.

module counter_step_mod #(
  parameter int M = 10,
  parameter int B = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [B-1:0] cnt_o
);

  localparam logic [B-1:0] MAX = B'(M - 1);

  logic [B-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + B'(1);
    end else if (dec_i) begin
      cnt_d = (cnt_q == '0) ? MAX : cnt_q - B'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

module counter_step_arbiter #(
  parameter int N  = 4,
  parameter int M  = 10,
  parameter int B  = $clog2(M),
  parameter int LW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    dir,
  input  logic [N*LW-1:0] len,
  output logic [N-1:0]    gnt,
  output logic            done,
  output logic            busy,
  output logic [B-1:0]    cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_STEP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic          dir_q, dir_d;
  logic [LW-1:0] rem_q, rem_d;

  logic          any_req;
  logic [PW-1:0] pick;
  logic [PW-1:0] arb_idx;
  logic [LW-1:0] len_f [N];
  logic          step_inc, step_dec;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      len_f[k] = len[k*LW +: LW];
    end
  end

  // Search starts at the round-robin pointer and wraps; first set request wins.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    arb_idx = '0;
    for (int k = 0; k < N; k++) begin
      arb_idx = PW'((int'(ptr_q) + k) % N);
      if (!any_req && req[arb_idx]) begin
        any_req = 1'b1;
        pick    = arb_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_GRANT;
      S_GRANT: state_d = (rem_q == '0) ? S_DONE : S_STEP;
      S_STEP:  if (rem_q == LW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Burst parameters are captured only in IDLE; later input changes are ignored.
  always_comb begin
    win_d = win_q;
    dir_d = dir_q;
    rem_d = rem_q;
    ptr_d = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d = pick;
          dir_d = dir[pick];
          rem_d = len_f[pick];
        end
      end
      S_STEP:  rem_d = rem_q - LW'(1);
      S_DONE:  ptr_d = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      dir_q <= 1'b0;
      rem_q <= '0;
      ptr_q <= '0;
    end else begin
      win_q <= win_d;
      dir_q <= dir_d;
      rem_q <= rem_d;
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    gnt      = '0;
    busy     = 1'b0;
    done     = 1'b0;
    step_inc = 1'b0;
    step_dec = 1'b0;
    case (state_q)
      S_GRANT: begin
        gnt[win_q] = 1'b1;
        busy       = 1'b1;
      end
      S_STEP: begin
        gnt[win_q] = 1'b1;
        busy       = 1'b1;
        step_inc   = dir_q;
        step_dec   = !dir_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  counter_step_mod #(
    .M(M),
    .B(B)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .inc_i(step_inc),
    .dec_i(step_dec),
    .cnt_o(cnt)
  );

  a_no_inc_and_dec: assert property (@(posedge clk) disable iff (rst) !(step_inc && step_dec));
  a_gnt_onehot0:    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule
